// File: rtl/sobel_3x3.sv
// Sobel 3x3 gradient magnitude with thresholded edge flag, border and sync masking.
// Four register stages: triple sums, Gx/Gy, absolute values, saturate/mask/threshold.
module sobel_3x3 #(
    parameter int DSIZE        = 8,
    parameter int VIDEO_WIDTH  = 1920,
    parameter int VIDEO_HEIGHT = 1080,
    parameter int THRESHOLD    = 128
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             invs,
    input  logic             inde,
    input  logic [DSIZE-1:0] indata_0_0,
    input  logic [DSIZE-1:0] indata_0_1,
    input  logic [DSIZE-1:0] indata_0_2,
    input  logic [DSIZE-1:0] indata_1_0,
    input  logic [DSIZE-1:0] indata_1_1,
    input  logic [DSIZE-1:0] indata_1_2,
    input  logic [DSIZE-1:0] indata_2_0,
    input  logic [DSIZE-1:0] indata_2_1,
    input  logic [DSIZE-1:0] indata_2_2,
    output logic             outvs,
    output logic             outde,
    output logic [DSIZE-1:0] outdata,
    output logic             outedge
);
    localparam int W  = DSIZE + 3;
    localparam int SW = DSIZE + 2;
    localparam int PW = 16;
    localparam logic [PW-1:0]    COL_LAST = PW'(VIDEO_WIDTH - 1);
    localparam logic [PW-1:0]    ROW_LAST = PW'(VIDEO_HEIGHT - 1);
    localparam logic [DSIZE-1:0] THR      = DSIZE'(THRESHOLD);

    function automatic logic [SW-1:0] wsum(input logic [DSIZE-1:0] a, b, c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    // position tracking and sync
    logic [PW-1:0] col, row;
    logic          prev_de, prev_vs, synced;
    logic          vs_rise, de_fall, border;

    assign vs_rise = invs & ~prev_vs;
    assign de_fall = prev_de & ~inde;
    assign border  = (col == '0) || (col >= COL_LAST) || (row == '0) || (row >= ROW_LAST);

    always_ff @(posedge clock) begin
        if (rst) begin
            col     <= '0;
            row     <= '0;
            prev_de <= 1'b0;
            prev_vs <= 1'b0;
            synced  <= 1'b0;
        end else begin
            prev_de <= inde;
            prev_vs <= invs;
            if (vs_rise) synced <= 1'b1;
            if (de_fall)                  col <= '0;
            else if (inde && col != '1)   col <= col + 1'b1;
            // frame start clears row even if a line ends in the same cycle
            if (vs_rise)                      row <= '0;
            else if (de_fall && row != '1)    row <= row + 1'b1;
        end
    end

    // datapath stage registers
    logic [SW-1:0]       s_r, s_l, s_b, s_t;
    logic signed [W-1:0] gx, gy;
    logic [SW-1:0]       ax, ay;
    logic [2:0]          pass_pipe;
    logic [3:0]          vs_pipe, de_pipe;

    logic signed [W-1:0] ngx, ngy;
    logic [W-1:0]        mag;
    logic [DSIZE-1:0]    sat;

    always_comb begin
        ngx = -gx;
        ngy = -gy;
        mag = {1'b0, ax} + {1'b0, ay};
        sat = (|mag[W-1:DSIZE]) ? '1 : mag[DSIZE-1:0];
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            s_r       <= '0;
            s_l       <= '0;
            s_b       <= '0;
            s_t       <= '0;
            gx        <= '0;
            gy        <= '0;
            ax        <= '0;
            ay        <= '0;
            pass_pipe <= '0;
            vs_pipe   <= '0;
            de_pipe   <= '0;
            outdata   <= '0;
            outedge   <= 1'b0;
        end else begin
            s_r <= wsum(indata_0_2, indata_1_2, indata_2_2);
            s_l <= wsum(indata_0_0, indata_1_0, indata_2_0);
            s_b <= wsum(indata_2_0, indata_2_1, indata_2_2);
            s_t <= wsum(indata_0_0, indata_0_1, indata_0_2);
            gx  <= $signed({1'b0, s_r}) - $signed({1'b0, s_l});
            gy  <= $signed({1'b0, s_b}) - $signed({1'b0, s_t});
            ax  <= gx[W-1] ? ngx[SW-1:0] : gx[SW-1:0];
            ay  <= gy[W-1] ? ngy[SW-1:0] : gy[SW-1:0];
            pass_pipe <= {pass_pipe[1:0], inde & synced & ~border};
            vs_pipe   <= {vs_pipe[2:0], invs};
            de_pipe   <= {de_pipe[2:0], inde};
            outdata   <= pass_pipe[2] ? sat : '0;
            outedge   <= pass_pipe[2] && (sat > THR);
        end
    end

    assign outvs = vs_pipe[3];
    assign outde = de_pipe[3];
endmodule

// File: tb/tb_sobel_3x3.sv
// Randomized frame stimulus for sobel_3x3 on an 8x4 image; a queue scoreboard checks each
// enabled output pixel against a direct arithmetic model of the Sobel rules.
module tb_sobel_3x3;
    localparam int VW  = 8;
    localparam int VH  = 4;
    localparam int THR = 128;

    typedef struct {
        logic [7:0] data;
        logic       edge_f;
    } exp_t;

    logic       clock = 1'b0;
    logic       rst   = 1'b1;
    logic       invs  = 1'b0;
    logic       inde  = 1'b0;
    logic [7:0] tp [0:2][0:2];
    logic       outvs, outde, outedge;
    logic [7:0] outdata;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   m_synced = 1'b0;
    logic [3:0] exp_vs = '0, exp_de = '0;

    always #5 clock = ~clock;

    sobel_3x3 #(.DSIZE(8), .VIDEO_WIDTH(VW), .VIDEO_HEIGHT(VH), .THRESHOLD(THR)) dut (
        .clock(clock), .rst(rst), .invs(invs), .inde(inde),
        .indata_0_0(tp[0][0]), .indata_0_1(tp[0][1]), .indata_0_2(tp[0][2]),
        .indata_1_0(tp[1][0]), .indata_1_1(tp[1][1]), .indata_1_2(tp[1][2]),
        .indata_2_0(tp[2][0]), .indata_2_1(tp[2][1]), .indata_2_2(tp[2][2]),
        .outvs(outvs), .outde(outde), .outdata(outdata), .outedge(outedge)
    );

    // sync/enable simply arrive four clocks later; a reset clears what is in flight
    always @(posedge clock) begin
        if (rst) begin
            exp_vs <= '0;
            exp_de <= '0;
        end else begin
            exp_vs <= {exp_vs[2:0], invs};
            exp_de <= {exp_de[2:0], inde};
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // monitor: pop one expected pixel for every enabled output
    always @(negedge clock) begin
        exp_t e;
        chk("outvs", int'(outvs), int'(exp_vs[3]));
        chk("outde", int'(outde), int'(exp_de[3]));
        if (outde) begin
            if (q.size() == 0) begin
                chk("unexpected_pixel", 1, 0);
            end else begin
                e = q.pop_front();
                chk("outdata", int'(outdata), int'(e.data));
                chk("outedge", int'(outedge), int'(e.edge_f));
            end
        end else begin
            chk("idle_data", int'(outdata), 0);
            chk("idle_edge", int'(outedge), 0);
        end
        if (rst) q.delete();
    end

    task automatic fill_taps(input int mode);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                case (mode)
                    1:       tp[r][c] = 8'd100;                                   // flat
                    2:       tp[r][c] = (c == 0) ? 8'd0 : (c == 1) ? 8'd128 : 8'd255; // step
                    3:       tp[r][c] = (c == 2) ? 8'd32 : 8'd0;                  // |G| = 128
                    4:       tp[r][c] = (c == 2) ? ((r == 2) ? 8'd33 : 8'd32) : 8'd0; // |G| = 130
                    default: tp[r][c] = 8'($urandom);
                endcase
    endtask

    // one clock of stimulus; pixel (x,y) counted from the start of the line/frame
    task automatic step(input bit vs, input bit de, input int x, input int y, input int mode);
        int p [0:2][0:2];
        int gx, gy, m;
        bit ok;
        exp_t e;
        @(posedge clock);
        #1;
        invs = vs;
        inde = de;
        fill_taps(mode);
        if (de && !rst) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    p[r][c] = int'(tp[r][c]);
            gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
            gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
            m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
            if (m > 255) m = 255;
            ok = m_synced && x > 0 && x < VW-1 && y > 0 && y < VH-1;
            e.data   = ok ? 8'(m) : 8'd0;
            e.edge_f = ok && (m > THR);
            q.push_back(e);
        end
        if (vs && !rst) m_synced = 1'b1;
    endtask

    task automatic frame(input int lines, input int len, input bit with_vs, input int mode);
        if (with_vs) begin
            repeat (2) step(1, 0, 0, 0, 0);
            repeat (2) step(0, 0, 0, 0, 0);
        end
        for (int y = 0; y < lines; y++) begin
            for (int x = 0; x < len; x++)
                step(0, 1, x, y, (mode < 0) ? int'($urandom_range(0, 4)) : mode);
            repeat (2) step(0, 0, 0, 0, 0);
        end
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clock);
        #1;
        rst = 1'b1;
        m_synced = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            inde = 1'b1;
            fill_taps(0);
            if (i < cycles - 1) begin
                @(posedge clock);
                #1;
            end
        end
        @(posedge clock);
        #1;
        rst  = 1'b0;
        inde = 1'b0;
    endtask

    initial begin
        int budget;
        fill_taps(1);
        do_reset(3);
        repeat (5) step(0, 0, 0, 0, 0);

        frame(4, VW, 0, 0);      // enabled but never synced -> zeros
        frame(4, VW, 1, 1);      // flat field
        frame(4, VW, 1, 2);      // vertical step
        frame(4, VW, 1, 3);      // threshold boundary, not above
        frame(4, VW, 1, 4);      // just above threshold
        for (int f = 0; f < 6; f++)
            frame(4, VW, 1, -1);
        frame(4, VW + 3, 1, -1); // overlong lines
        frame(6, VW, 1, -1);     // overtall frame
        frame(2, VW, 1, -1);     // short frame
        frame(4, VW, 1, 2);

        // reset in the middle of a line
        frame(1, 3, 1, 2);
        for (int x = 0; x < 3; x++) step(0, 1, x, 1, 2);
        do_reset(2);
        repeat (6) step(0, 0, 0, 0, 0);
        frame(4, VW, 1, -1);

        budget = 0;
        while (q.size() != 0 && budget < 20) begin
            @(posedge clock);
            budget++;
        end
        chk("scoreboard_drained", q.size(), 0);
        repeat (2) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
